// File: rtl/uart_tx_bridge.sv
// USB OUT byte stream to 8N1 UART transmitter with a power-of-two byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
`timescale 1ns/1ps
module uart_tx_bridge #(
  parameter int unsigned DIV   = 104,
  parameter int unsigned DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxact,
  input  logic       rxval,
  input  logic [7:0] rxdat,
  output logic       rxrdy,
  output logic       uart_txd,
  output logic       busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  state_t        state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shreg_q;
  logic          txd_q;
  logic          push, pop, baud_end;
  logic [7:0]    head;

  assign rxrdy    = !rst && (count_q != FULL);
  assign push     = rxact && rxval && rxrdy;
  assign baud_end = (baud_q == BAUD_LAST);
  // The serializer takes the head either from idle or at the very end of a stop bit.
  assign pop      = (count_q != '0) &&
                    ((state_q == IDLE) || ((state_q == STOP) && baud_end));
  assign head     = mem_q[rptr_q];
  assign busy     = (state_q != IDLE) || (count_q != '0);
  assign uart_txd = txd_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CW'(1);
    else if (pop && !push)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wptr_q] <= rxdat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)
        wptr_q <= wptr_q + AW'(1);
      if (pop)
        rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_q <= '0;
          txd_q  <= 1'b1;
          if (pop) begin
            shreg_q <= head;
            state_q <= START;
            txd_q   <= 1'b0;
          end
        end
        START: begin
          if (baud_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
            txd_q   <= shreg_q[0];
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        DATA: begin
          // Data stays unshifted so the parity bit can still see all eight bits.
          if (baud_end) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
              txd_q   <= ^shreg_q;
`else
              state_q <= STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
              txd_q <= shreg_q[bit_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_q  <= '0;
            state_q <= STOP;
            txd_q   <= 1'b1;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud_q <= '0;
            if (pop) begin
              shreg_q <= head;
              state_q <= START;
              txd_q   <= 1'b0;
            end else begin
              state_q <= IDLE;
              txd_q   <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          baud_q  <= '0;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_bridge.sv
// Scoreboard bench for uart_tx_bridge: driver queues expected bytes, a serial-line monitor decodes frames.
`timescale 1ns/1ps
module tb_uart_tx_bridge;
  localparam int unsigned DIV   = 4;
  localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * DIV;

  logic       clk = 1'b0;
  logic       rst, rxact, rxval;
  logic [7:0] rxdat;
  logic       rxrdy, uart_txd, busy;

  uart_tx_bridge #(.DIV(DIV), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rxact(rxact), .rxval(rxval), .rxdat(rxdat),
    .rxrdy(rxrdy), .uart_txd(uart_txd), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  int start_q[$];
  int frames_seen = 0;

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference frame: start 0, data LSB first, optional even parity, stop 1.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    int ones;
    f = '1;
    f[0] = 1'b0;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      f[i+1] = b[i];
      ones += int'(b[i]);
    end
`ifdef UART_TX_PARITY_EN
    f[9] = ((ones % 2) == 1);
`endif
    return f;
  endfunction

  // Monitor: on every start bit, pop the expected byte and compare every sample of the frame.
  initial begin
    int s;
    int bad;
    bit aborted;
    logic [7:0] b;
    logic [10:0] fb;
    forever begin
      @(negedge clk);
      if (!rst && uart_txd === 1'b0) begin
        s = cyc;
        frames_seen++;
        start_q.push_back(s);
        check("frame_expected", int'(exp_q.size() > 0), 1);
        b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        fb = frame_bits(b);
        bad = 0;
        aborted = 0;
        for (int j = 0; j < FRAME; j++) begin
          if (j > 0) @(negedge clk);
          if (rst) begin
            aborted = 1;
            break;
          end
          if (uart_txd !== fb[j / DIV]) bad++;
        end
        if (!aborted) check($sformatf("frame_%02h_bad_samples", b), bad, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n;
    n = 0;
    rxact = 1'b1;
    rxval = 1'b1;
    rxdat = b;
    while (rxrdy !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    check("push_ready_wait", int'(n < 2000), 1);
    tick();
    exp_q.push_back(b);
    rxact = 1'b0;
    rxval = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      tick();
      n++;
    end
    check("drain_within_budget", int'(n < budget), 1);
  endtask

  initial begin
    int pcyc, s, fs, bad;
    logic [7:0] b;
    rst = 1'b1; rxact = 1'b0; rxval = 1'b0; rxdat = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("reset_txd", uart_txd, 1);
    check("reset_rxrdy", rxrdy, 0);
    check("reset_busy", busy, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    check("rxrdy_after_reset", rxrdy, 1);
    tick();

    // Single 0x96 frame: latency, length and idle afterwards.
    start_q.delete();
    pcyc = cyc;
    push_byte(8'h96);
    while (cyc < pcyc + 1 + FRAME) @(negedge clk);
    check("busy_last_frame_cycle", busy, 1);
    @(negedge clk);
    check("busy_after_frame", busy, 0);
    check("txd_idle_after_frame", uart_txd, 1);
    check("single_start_count", start_q.size(), 1);
    if (start_q.size() > 0) check("start_latency", start_q[0] - pcyc, 2);
    tick();

    // Back-to-back frames: no idle bit between them.
    start_q.delete();
    pcyc = cyc;
    push_byte(8'h55);
    push_byte(8'hAA);
    bad = 0;
    while (start_q.size() < 2 && bad < 4 * FRAME) begin
      tick();
      bad++;
    end
    check("b2b_two_starts", int'(start_q.size() >= 2), 1);
    if (start_q.size() >= 2) begin
      check("b2b_first_latency", start_q[0] - pcyc, 2);
      check("b2b_gap", start_q[1] - start_q[0], FRAME);
    end
    wait_idle(4 * FRAME);

    // rxval without rxact is ignored.
    fs = frames_seen;
    rxact = 1'b0; rxval = 1'b1; rxdat = 8'h42;
    tick();
    rxval = 1'b0;
    bad = 0;
    repeat (12) begin
      if (busy !== 1'b0 || uart_txd !== 1'b1) bad++;
      tick();
    end
    check("ignored_push_quiet", bad, 0);
    check("ignored_push_no_frame", frames_seen - fs, 0);

    // Continuous burst from idle: one byte leaves for the serializer, DEPTH more fill the FIFO.
    for (int k = 0; k < int'(DEPTH) + 3; k++) begin
      rxact = 1'b1; rxval = 1'b1; rxdat = 8'(8'hC0 + k);
      check($sformatf("burst_rxrdy_%0d", k), rxrdy, int'(k <= int'(DEPTH)));
      if (k <= int'(DEPTH)) exp_q.push_back(8'(8'hC0 + k));
      tick();
    end
    rxact = 1'b0; rxval = 1'b0;
    wait_idle((DEPTH + 3) * FRAME);

    // Reset during data bit 3 with three bytes queued behind the active frame.
    start_q.delete();
    pcyc = cyc;
    b = 8'($urandom) & 8'hF7;
    push_byte(b);
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    s = pcyc + 2;
    while (cyc < s + 4 * int'(DIV) + 1) tick();
    check("pre_reset_bit3_low", uart_txd, 0);
    rst = 1'b1;
    #1;
    check("rst_txd_immediate", uart_txd, 1);
    check("rst_rxrdy", rxrdy, 0);
    check("rst_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    tick();
    check("post_rst_rxrdy", rxrdy, 1);
    check("post_rst_busy", busy, 0);
    check("post_rst_txd", uart_txd, 1);
    fs = frames_seen;
    repeat (3 * FRAME) tick();
    check("post_rst_no_frames", frames_seen - fs, 0);
    check("post_rst_still_idle", busy, 0);

    // Randomized traffic with junk cycles between pushes.
    repeat (40) begin
      repeat ($urandom_range(0, 3)) begin
        case ($urandom_range(0, 2))
          0: begin rxact = 1'b0; rxval = 1'b0; end
          1: begin rxact = 1'b0; rxval = 1'b1; end
          default: begin rxact = 1'b1; rxval = 1'b0; end
        endcase
        rxdat = 8'($urandom);
        tick();
      end
      push_byte(8'($urandom));
    end
    rxact = 1'b0; rxval = 1'b0;
    wait_idle((DEPTH + 3) * FRAME);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end
endmodule
